// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath/cache.
// Valid/ready: MemRead/MemWrite is the request (held constant); MemReady completes it in the same cycle.
interface multicycle_controller_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               Zero;
    logic               MemReady;
    logic               MemRead;
    logic               MemWrite;
    logic               AdrSrc;
    logic               IRWrite;
    logic               PCWrite;
    logic               RegWrite;
    logic [1:0]         ImmSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUControl;
    logic [1:0]         ResultSrc;
    logic               IllegalOp;
    logic [STATE_W-1:0] Dbg_State;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, IllegalOp, Dbg_State
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, IllegalOp, Dbg_State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback over a shared ALU,
// stalling on the cache MemReady handshake. The state register is the only flop.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_adrsrc;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_resultsrc;
    logic [2:0] w_alucontrol;
    logic [1:0] w_immsrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_adrsrc    = 1'b0;
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        w_resultsrc = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memread   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = bus.MemReady;
                w_pcwrite   = bus.MemReady;
                if (bus.MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is parked in ALUOut for BEQ.
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100011:             w_next = S_BEQ;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_memread = 1'b1;
                w_adrsrc  = 1'b1;
                if (bus.MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_memwrite = 1'b1;
                w_adrsrc   = 1'b1;
                if (bus.MemReady) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut; ALU forms OldPC+4 for rd.
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_pcwrite = bus.Zero ^ bus.funct3[0];
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_alucontrol = 3'b000;
        case (w_aluop)
            2'b01: w_alucontrol = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alucontrol = 3'b101;
                    3'b110:  w_alucontrol = 3'b011;
                    3'b111:  w_alucontrol = 3'b010;
                    default: w_alucontrol = 3'b000;
                endcase
            end
            default: w_alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        w_immsrc = 2'b00;
        case (bus.op)
            7'b0100011: w_immsrc = 2'b01;
            7'b1100011: w_immsrc = 2'b10;
            7'b1101111: w_immsrc = 2'b11;
            default:    w_immsrc = 2'b00;
        endcase
    end

    // Enables and requests drop combinationally with reset, even mid-transfer.
    assign bus.MemRead    = w_memread  & ~reset;
    assign bus.MemWrite   = w_memwrite & ~reset;
    assign bus.IRWrite    = w_irwrite  & ~reset;
    assign bus.PCWrite    = w_pcwrite  & ~reset;
    assign bus.RegWrite   = w_regwrite & ~reset;
    assign bus.IllegalOp  = w_illegal  & ~reset;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUControl = w_alucontrol;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.Dbg_State  = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle output vectors, compared every cycle.
module tb_multicycle_controller;
    localparam int W = 22;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [W-1:0] exp_q[$];
    logic [1:0]   drv_q[$];

    multicycle_controller_if #(.STATE_W(4)) bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] obs();
        return {bus.Dbg_State, bus.MemRead, bus.MemWrite, bus.AdrSrc, bus.IRWrite,
                bus.PCWrite, bus.RegWrite, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.ResultSrc, bus.IllegalOp};
    endfunction

    function automatic logic [5:0] enables();
        return {bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.IllegalOp};
    endfunction

    function automatic logic [W-1:0] rec(
        input logic [3:0] st, input logic mr, input logic mw, input logic adr,
        input logic irw, input logic pcw, input logic rw, input logic [1:0] imm,
        input logic [1:0] a, input logic [1:0] b, input logic [2:0] alu,
        input logic [1:0] res, input logic ill);
        return {st, mr, mw, adr, irw, pcw, rw, imm, a, b, alu, res, ill};
    endfunction

    // ALU operation an ALU-class instruction asks for (RV32I semantics).
    function automatic logic [2:0] exp_alu(input logic is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic plan(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input int fw, input int mwt);
        logic [1:0] imm;
        logic       legal;
        imm = 2'b00;
        if (op == 7'b0100011) imm = 2'b01;
        if (op == 7'b1100011) imm = 2'b10;
        if (op == 7'b1101111) imm = 2'b11;
        legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
                (op == 7'b0010011) || (op == 7'b1101111) || (op == 7'b1100011);
        for (int i = 0; i < fw; i++) begin
            drv_q.push_back({1'b0, rbit()});
            exp_q.push_back(rec(0, 1, 0, 0, 0, 0, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10, 0));
        end
        drv_q.push_back({1'b1, rbit()});
        exp_q.push_back(rec(0, 1, 0, 0, 1, 1, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10, 0));
        drv_q.push_back({rbit(), rbit()});
        exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, imm, 2'b01, 2'b01, 3'b000, 2'b00, !legal));
        if (op == 7'b0000011 || op == 7'b0100011) begin
            drv_q.push_back({rbit(), rbit()});
            exp_q.push_back(rec(2, 0, 0, 0, 0, 0, 0, imm, 2'b10, 2'b01, 3'b000, 2'b00, 0));
            for (int i = 0; i <= mwt; i++) begin
                drv_q.push_back({(i == mwt), rbit()});
                if (op == 7'b0000011)
                    exp_q.push_back(rec(3, 1, 0, 1, 0, 0, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0));
                else
                    exp_q.push_back(rec(5, 0, 1, 1, 0, 0, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0));
            end
            if (op == 7'b0000011) begin
                drv_q.push_back({rbit(), rbit()});
                exp_q.push_back(rec(4, 0, 0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b01, 0));
            end
        end else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1101111) begin
            drv_q.push_back({rbit(), rbit()});
            if (op == 7'b0110011)
                exp_q.push_back(rec(6, 0, 0, 0, 0, 0, 0, imm, 2'b10, 2'b00, exp_alu(1, f3, f7), 2'b00, 0));
            else if (op == 7'b0010011)
                exp_q.push_back(rec(7, 0, 0, 0, 0, 0, 0, imm, 2'b10, 2'b01, exp_alu(0, f3, f7), 2'b00, 0));
            else
                exp_q.push_back(rec(9, 0, 0, 0, 0, 1, 0, imm, 2'b01, 2'b10, 3'b000, 2'b00, 0));
            drv_q.push_back({rbit(), rbit()});
            exp_q.push_back(rec(8, 0, 0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        end else if (op == 7'b1100011) begin
            drv_q.push_back({rbit(), z});
            exp_q.push_back(rec(10, 0, 0, 0, 0, z ^ f3[0], 0, imm, 2'b10, 2'b00, 3'b001, 2'b00, 0));
        end
    endtask

    // Entered and left at posedge+1.
    task automatic step();
        logic [1:0]   d;
        logic [W-1:0] e;
        d = drv_q.pop_front();
        e = exp_q.pop_front();
        bus.MemReady = d[1];
        bus.Zero     = d[0];
        @(negedge clk);
        check($sformatf("st%0d", e[W-1:W-4]), 32'(obs()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int mwt);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        plan(op, f3, f7, z, fw, mwt);
        while (exp_q.size() > 0) step();
    endtask

    initial begin
        logic [6:0] rop;
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.op       = 7'b0000011;
        bus.funct3   = 3'b010;
        bus.funct7b5 = 1'b0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_en", 32'(enables()), 32'd0);
            check("rst_st", 32'(bus.Dbg_State), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_instr(7'b0000011, 3'b010, 0, 0, 0, 3);  // lw, 3 wait cycles in MEMREAD
        do_instr(7'b0100011, 3'b010, 0, 0, 1, 2);  // sw
        do_instr(7'b0110011, 3'b000, 1, 0, 0, 0);  // sub
        do_instr(7'b0110011, 3'b000, 0, 0, 0, 0);  // add
        do_instr(7'b0010011, 3'b000, 1, 0, 0, 0);  // addi, funct7b5 set
        do_instr(7'b0110011, 3'b111, 0, 0, 0, 0);  // and
        do_instr(7'b1100011, 3'b000, 0, 1, 0, 0);  // beq taken
        do_instr(7'b1100011, 3'b000, 0, 0, 0, 0);  // beq not taken
        do_instr(7'b1100011, 3'b001, 0, 0, 0, 0);  // bne taken
        do_instr(7'b1101111, 3'b000, 0, 0, 0, 0);  // jal
        do_instr(7'b1110011, 3'b000, 0, 0, 0, 0);  // illegal

        // Reset during MEMWRITE while the cache is ready: request must drop at once.
        bus.op       = 7'b0100011;
        bus.funct3   = 3'b010;
        bus.funct7b5 = 1'b0;
        plan(7'b0100011, 3'b010, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        exp_q.delete();
        drv_q.delete();
        bus.MemReady = 1'b1;
        #2;
        check("mw_pre", 32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mw", 32'(bus.MemWrite), 32'd0);
        check("rst_async_st", 32'(bus.Dbg_State), 32'd0);
        check("rst_mid_en", 32'(enables()), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_st", 32'(bus.Dbg_State), 32'd0);
        check("rst_hold_en", 32'(enables()), 32'd0);
        reset = 1'b0;

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0:       rop = 7'b0000011;
                1:       rop = 7'b0100011;
                2:       rop = 7'b0110011;
                3:       rop = 7'b0010011;
                4:       rop = 7'b1101111;
                5:       rop = 7'b1100011;
                default: rop = 7'($urandom_range(0, 127));
            endcase
            do_instr(rop, 3'($urandom_range(0, 7)), rbit(), rbit(),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared ALU, the immediate extender, the register file and the unified cache port.
- Drives the extender's 2-bit ImmSrc select and all datapath mux and enable signals.
- Stalls on the cache's MemReady handshake.
- Supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal.

Parameters:
- STATE_W, 4, width of the state register and Dbg_State port.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7b5  input  1  instruction[30]
- Zero  input  1  ALU zero flag
- MemReady  input  1  cache completes the current access this cycle
- MemRead  output  1  cache read request
- MemWrite  output  1  cache write request
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- IRWrite  output  1  latch instruction and OldPC
- PCWrite  output  1  PC load enable
- RegWrite  output  1  register-file write enable
- ImmSrc  output  2  extender select: 00=I, 01=S, 10=B, 11=J
- ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 data
- ALUSrcB  output  2  ALU B select: 00=rs2 data, 01=ImmExt, 10=constant 4
- ALUControl  output  3  ALU operation: 000=add, 001=sub, 010=and, 011=or, 101=slt
- ResultSrc  output  2  result mux select: 00=ALUOut, 01=ReadData, 10=ALU result
- IllegalOp  output  1  one-cycle pulse in DECODE for an unsupported opcode
- Dbg_State  output  STATE_W  current state

Behaviour:
- Reset and output timing
  - The state register is the only flop.
  - reset is asynchronous: state goes to FETCH (0) immediately.
  - While reset is high, all enables and requests are forced to 0: MemRead, MemWrite, IRWrite, PCWrite, RegWrite, IllegalOp.
  - Select outputs are combinational from state and are don't-care while reset is high.
  - Unlisted outputs are 0 in every state.
  - ImmSrc is decoded from op in every state: sw=01, beq/bne=10, jal=11, otherwise 00.
- ALU decoder (internal ALUOp)
  - ALUOp 00 = add; ALUOp 01 = sub.
  - ALUOp 10 decodes funct3:
    - 000: sub if op[5] and funct7b5 are both 1, else add.
    - 010: slt. 110: or. 111: and.
    - any other funct3: add.
- Cache handshake
  - A request (MemRead or MemWrite) is held constant until the cycle in which MemReady=1; the transfer completes in that cycle.
  - Write enables that accompany the transfer (IRWrite, PCWrite in FETCH) assert only when MemReady=1.
  - No cycle limit on the wait.
- States and transitions
  - FETCH(0): MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
    - MemReady=1: IRWrite=1, PCWrite=1, go to DECODE.
    - MemReady=0: stay.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECR.
    - 0010011: EXECI.
    - 1101111: JAL.
    - 1100011: BEQ.
    - anything else: IllegalOp=1, go to FETCH.
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD(3): MemRead=1, AdrSrc=1. Go to MEMWB when MemReady=1.
  - MEMWB(4): ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE(5): MemWrite=1, AdrSrc=1. Go to FETCH when MemReady=1.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1. Go to FETCH.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB, which writes OldPC+4 to rd.
  - BEQ(10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
    - PCWrite = Zero XOR funct3[0] (funct3=000 is beq, 001 is bne).
    - Go to FETCH.
  - Codes 11-15: all outputs default; go to FETCH next cycle.
- Latency with zero-wait cache: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
- Reset asserted mid-access drops the request in the same cycle, even if MemReady=1; no IRWrite, PCWrite or RegWrite occurs.

Test Plan:
- Reset held 3 cycles, then released with MemReady=1 -> enables 0 during reset; cycle 1 after release: FETCH, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=10; next Dbg_State=1.
- lw (op=0000011), MemReady low for 3 cycles in MEMREAD -> states 1,2,3,3,3,3,4,0; AdrSrc=1 throughout MEMREAD; RegWrite=1 with ResultSrc=01 only in MEMWB; ImmSrc=00.
- sw (op=0100011) -> ImmSrc=01; MEMWRITE has MemWrite=1; RegWrite never asserts; back to FETCH on MemReady.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECR ALUControl=001; R-type funct7b5=0 gives 000; I-type (op=0010011, funct7b5=1) gives 000, not sub; funct3=111 gives 010.
- beq/bne/jal:
  - beq: funct3=000, Zero=1 -> PCWrite=1 in state 10; Zero=0 -> PCWrite=0.
  - bne: funct3=001, Zero=0 -> PCWrite=1.
  - jal: state 9 has PCWrite=1 and ImmSrc=11, then state 8 has RegWrite=1.
- op=1110011 -> IllegalOp=1 for one cycle in DECODE, then FETCH; reset pulse during MEMWRITE with MemReady=1 -> MemWrite=0 that cycle; state=0 asynchronously.
